// File: rtl/ddr_readback_ctrl.sv
// ddr_readback_ctrl: streams a captured record out of LPDDR, one block per DDR read request.
// Each block is requested from ddr_top and, once loaded, drained from the read FIFO through a
// one-entry skid register into the UART TX byte path.
// Optional feature: define READBACK_CHECKSUM_EN to append a mod-256 sum byte after the data.
module ddr_readback_ctrl #(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned BLOCK_BYTES = 256,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  byte_count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              ddr_rd_req_o,
    input  logic              ddr_rd_done_i,
    output logic [ADDR_W-1:0] ddr_address_o,
    output logic              fifo_rd_en_o,
    input  logic              fifo_empty_i,
    input  logic [7:0]        fifo_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    localparam int unsigned BLK_W = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReq    = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StTail   = 3'd4;
    localparam logic [2:0] StFinish = 3'd5;

    logic [2:0]        state_q,      state_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [CNT_W-1:0]  remain_q,     remain_d;
    logic [BLK_W-1:0]  blk_left_q,   blk_left_d;
    logic [TMR_W-1:0]  timer_q,      timer_d;
    logic              timeout_q,    timeout_d;
    logic              pend_q,       pend_d;
    logic              skid_valid_q, skid_valid_d;
    logic [7:0]        skid_data_q,  skid_data_d;
`ifdef READBACK_CHECKSUM_EN
    logic [7:0]        sum_q,        sum_d;
`endif

    logic             slot_full;
    logic             tx_accept;
    logic             block_end;
    logic [BLK_W-1:0] blk_init;

    // The slot holds one byte: either arriving from the FIFO this cycle (pend) or parked in skid.
    assign slot_full = skid_valid_q | pend_q;
    assign tx_accept = tx_valid_o & tx_ready_i;
    assign block_end = (state_q == StDrain) && (blk_left_q == '0) && !slot_full;
    assign blk_init  = (remain_q >= CNT_W'(BLOCK_BYTES)) ? BLK_W'(BLOCK_BYTES)
                                                         : BLK_W'(remain_q);

    assign busy_o        = (state_q == StReq) || (state_q == StWait) ||
                           (state_q == StDrain) || (state_q == StTail);
    assign done_o        = (state_q == StFinish);
    assign timeout_o     = timeout_q;
    assign ddr_rd_req_o  = (state_q == StWait);
    assign ddr_address_o = addr_q;

    // Read only when the byte it yields has a free slot next cycle and belongs to this block.
    assign fifo_rd_en_o = (state_q == StDrain) && !abort_i && !fifo_empty_i &&
                          (blk_left_q != '0) && (!slot_full || tx_accept);

    // TX byte source: FIFO data directly on the cycle it arrives, else the skid copy.
    always_comb begin
        tx_valid_o = (state_q == StDrain) && slot_full;
        tx_data_o  = pend_q ? fifo_data_i : skid_data_q;
`ifdef READBACK_CHECKSUM_EN
        if (state_q == StTail) begin
            tx_valid_o = 1'b1;
            tx_data_o  = sum_q;
        end
`endif
    end

    // Next-state: transfer sequencing, skid bookkeeping and counters.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        blk_left_d   = blk_left_q;
        timer_d      = timer_q;
        timeout_d    = timeout_q;
        pend_d       = fifo_rd_en_o;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
`ifdef READBACK_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        if (pend_q && !tx_accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = fifo_data_i;
        end else if (skid_valid_q && tx_accept) begin
            skid_valid_d = 1'b0;
        end

        if (fifo_rd_en_o) begin
            blk_left_d = blk_left_q - BLK_W'(1);
        end

        if ((state_q == StDrain) && tx_accept) begin
            if (remain_q != '0) begin
                remain_d = remain_q - CNT_W'(1);
            end
`ifdef READBACK_CHECKSUM_EN
            sum_d = sum_q + tx_data_o;
`endif
        end

        case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    timeout_d = 1'b0;
                    if (byte_count_i == '0) begin
                        state_d = StFinish;
                    end else begin
                        addr_d   = base_addr_i;
                        remain_d = byte_count_i;
`ifdef READBACK_CHECKSUM_EN
                        sum_d    = 8'h00;
`endif
                        state_d  = StReq;
                    end
                end
            end
            StReq: begin
                timer_d = '0;
                // Hold off until ddr_top has released the previous handshake.
                if (!ddr_rd_done_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (ddr_rd_done_i) begin
                    blk_left_d = blk_init;
                    state_d    = StDrain;
                end else if (timer_q == TmrLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StDrain: begin
                if (block_end) begin
                    addr_d = addr_q + ADDR_W'(BLOCK_BYTES);
                    if (remain_q != '0) begin
                        state_d = StReq;
                    end else begin
`ifdef READBACK_CHECKSUM_EN
                        state_d = StTail;
`else
                        state_d = StFinish;
`endif
                    end
                end
            end
`ifdef READBACK_CHECKSUM_EN
            StTail: begin
                if (tx_accept) begin
                    state_d = StFinish;
                end
            end
`endif
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort discards any in-flight byte and returns to idle without done_o.
        if (abort_i) begin
            state_d      = StIdle;
            pend_d       = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remain_q     <= '0;
            blk_left_q   <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            pend_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= 8'h00;
`ifdef READBACK_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            blk_left_q   <= blk_left_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            pend_q       <= pend_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
`ifdef READBACK_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr_readback_ctrl.sv
// Bench for ddr_readback_ctrl: models ddr_top (block load into a FIFO queue) and a UART with
// random/toggling ready, and checks each transfer against the expected byte stream.
module tb_ddr_readback_ctrl;

    localparam int unsigned BLK = 256;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, abort_i;
    logic [29:0] base_addr_i;
    logic [23:0] byte_count_i;
    logic        busy_o, done_o, timeout_o;
    logic        ddr_rd_req_o, ddr_rd_done_i;
    logic [29:0] ddr_address_o;
    logic        fifo_rd_en_o, fifo_empty_i;
    logic [7:0]  fifo_data_i, tx_data_o;
    logic        tx_valid_o, tx_ready_i;

    ddr_readback_ctrl #(
        .ADDR_W      (30),
        .CNT_W       (24),
        .BLOCK_BYTES (BLK),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .base_addr_i   (base_addr_i),
        .byte_count_i  (byte_count_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o),
        .ddr_rd_req_o  (ddr_rd_req_o),
        .ddr_rd_done_i (ddr_rd_done_i),
        .ddr_address_o (ddr_address_o),
        .fifo_rd_en_o  (fifo_rd_en_o),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_data_i   (fifo_data_i),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Environment model state
    logic [7:0]  fifo_q[$];
    bit          rd_seen, req_seen, no_resp, stall_en;
    logic [29:0] req_addr_seen;
    int          ddr_delay, stall_left, ready_mode;

    // Per-transfer observations
    logic [29:0] req_addrs[$];
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          rd_cnt, done_cnt, req_hi_cnt, viol, req_lat, start_cyc, rd_in_blk;
    bit          prev_hold, busy_at1;
    logic [7:0]  prev_data;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory content: consecutive addresses from 0x100 read 0x11, 0x12, ...
    function automatic logic [7:0] mem_byte(input logic [29:0] a);
        return a[7:0] + (a[15:8] ^ 8'h10) + (a[23:16] * 8'd3) + {2'b00, a[29:24]};
    endfunction

    task automatic clear_stats();
        req_addrs.delete();
        got.delete();
        rd_cnt = 0; done_cnt = 0; req_hi_cnt = 0; viol = 0; req_lat = -1;
        start_cyc = -10; rd_in_blk = 0; prev_hold = 0; busy_at1 = 0;
    endtask

    // One clock: drive inputs just after posedge, observe outputs at negedge.
    task automatic tick(input bit st, input bit ab);
        @(posedge clk);
        #1;
        cyc++;
        start_i = st;
        abort_i = ab;
        if (rd_seen) begin
            if (fifo_q.size() != 0) fifo_data_i = fifo_q.pop_front();
            else viol++;
        end
        if (req_seen) begin
            if (!ddr_rd_done_i && !no_resp) begin
                if (ddr_delay == 0) begin
                    fifo_q.delete();
                    for (int j = 0; j < BLK; j++) fifo_q.push_back(mem_byte(req_addr_seen + 30'(j)));
                    ddr_rd_done_i = 1'b1;
                end else begin
                    ddr_delay--;
                end
            end
        end else begin
            ddr_rd_done_i = 1'b0;
            ddr_delay     = $urandom_range(0, 6);
        end
        if (stall_en && stall_left == 0 && $urandom_range(0, 19) == 0) stall_left = 5;
        if (stall_left > 0) begin
            fifo_empty_i = 1'b1;
            stall_left--;
        end else begin
            fifo_empty_i = (fifo_q.size() == 0);
        end
        case (ready_mode)
            0:       tx_ready_i = 1'b1;
            1:       tx_ready_i = (cyc % 2 == 0);
            default: tx_ready_i = 1'($urandom_range(0, 1));
        endcase

        @(negedge clk);
        if (cyc == start_cyc + 1) busy_at1 = busy_o;
        if (ddr_rd_req_o && !req_seen) begin
            req_addrs.push_back(ddr_address_o);
            rd_in_blk = 0;
            if (req_addrs.size() == 1) req_lat = cyc - start_cyc;
        end
        if (ddr_rd_req_o && req_seen && ddr_address_o != req_addr_seen) viol++;
        if (fifo_rd_en_o) begin
            rd_cnt++;
            rd_in_blk++;
            if (fifo_empty_i) viol++;
            if (rd_in_blk > BLK) viol++;
        end
        if (prev_hold && (!tx_valid_o || tx_data_o != prev_data)) viol++;
        if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
        prev_hold = tx_valid_o && !tx_ready_i && !ab;
        prev_data = tx_data_o;
        if (done_o) done_cnt++;
        if (ddr_rd_req_o) req_hi_cnt++;
        req_seen      = ddr_rd_req_o;
        req_addr_seen = ddr_address_o;
        rd_seen       = fifo_rd_en_o;
    endtask

    // Reference stream: cnt bytes read block by block from wrapping block addresses.
    task automatic build_exp(input logic [29:0] base, input int cnt);
        logic [7:0]  sum;
        logic [29:0] a;
        exp_q.delete();
        sum = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            a = base + 30'((i / BLK) * BLK) + 30'(i % BLK);
            exp_q.push_back(mem_byte(a));
            sum = sum + mem_byte(a);
        end
`ifdef READBACK_CHECKSUM_EN
        if (cnt > 0) exp_q.push_back(sum);
`endif
    endtask

    function automatic int prefix_mism();
        int m = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic run_xfer(input string tag, input logic [29:0] base, input int cnt,
                            input int rmode, input bit stl);
        int budget = 0;
        int amis   = 0;
        int nblk;
        clear_stats();
        ready_mode   = rmode;
        stall_en     = stl;
        base_addr_i  = base;
        byte_count_i = 24'(cnt);
        tick(1'b1, 1'b0);
        start_cyc = cyc;
        while (done_cnt == 0 && !timeout_o && budget < 20000) begin
            tick(1'b0, 1'b0);
            budget++;
        end
        check_val({tag, "_in_time"}, budget < 20000, 1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        build_exp(base, cnt);
        nblk = (cnt + BLK - 1) / BLK;
        for (int k = 0; k < req_addrs.size() && k < nblk; k++)
            if (req_addrs[k] !== base + 30'(k * BLK)) amis++;
        check_val({tag, "_len"}, got.size(), exp_q.size());
        check_val({tag, "_data"}, prefix_mism(), 0);
        check_val({tag, "_nreq"}, req_addrs.size(), nblk);
        check_val({tag, "_reqaddr"}, amis, 0);
        check_val({tag, "_rd_en"}, rd_cnt, cnt);
        check_val({tag, "_done"}, done_cnt, 1);
        check_val({tag, "_protocol"}, viol, 0);
        check_val({tag, "_busy_end"}, busy_o, 0);
        check_val({tag, "_timeout"}, timeout_o, 0);
        check_val({tag, "_busy_start"}, busy_at1, cnt > 0);
        if (cnt > 0) check_val({tag, "_req_lat"}, req_lat, 2);
    endtask

    task automatic model_reset();
        fifo_q.delete();
        rd_seen = 0; req_seen = 0; no_resp = 0; stall_en = 0; stall_left = 0;
        ddr_rd_done_i = 1'b0; fifo_empty_i = 1'b1; prev_hold = 0;
    endtask

    initial begin
        int budget;
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; base_addr_i = '0; byte_count_i = '0;
        fifo_data_i = 8'h00; tx_ready_i = 1'b1; ready_mode = 0; ddr_delay = 0;
        model_reset();
        clear_stats();
        #12;
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_timeout", timeout_o, 0);
        check_val("rst_req", ddr_rd_req_o, 0);
        check_val("rst_rd_en", fifo_rd_en_o, 0);
        check_val("rst_tx_valid", tx_valid_o, 0);
        check_val("rst_addr", ddr_address_o, 0);
        check_val("rst_tx_data", tx_data_o, 0);
        #11 reset = 1'b0;
        tick(1'b0, 1'b0);

        run_xfer("basic4", 30'h100, 4, 0, 1'b0);
        check_val("basic4_b0", got[0], 8'h11);
        check_val("basic4_b3", got[3], 8'h14);
        check_val("basic4_addr", req_addrs[0], 30'h100);
`ifdef READBACK_CHECKSUM_EN
        check_val("basic4_csum", got[4], 8'h50);
`endif
        run_xfer("blk600", 30'h1000, 600, 0, 1'b0);
        run_xfer("toggle", 30'($urandom), 300, 1, 1'b0);
        run_xfer("stall", 30'($urandom), 400, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [29:0] b;
            b = (i % 3 == 0) ? 30'h3FFF_FF00 + 30'($urandom_range(0, 255)) : 30'($urandom);
            run_xfer("rand", b, $urandom_range(1, 700), i % 3, 1'b1);
        end
        run_xfer("zero", 30'h0, 0, 0, 1'b0);

        // DDR never answers: request must time out after TMO waiting cycles.
        clear_stats();
        no_resp = 1;
        base_addr_i = 30'h2000;
        byte_count_i = 24'd300;
        tick(1'b1, 1'b0);
        budget = 0;
        while ((budget < 3 || busy_o) && budget < 200) begin
            tick(1'b0, 1'b0);
            budget++;
        end
        check_val("tmo_in_time", budget < 200, 1);
        check_val("tmo_req_cycles", req_hi_cnt, TMO);
        check_val("tmo_flag", timeout_o, 1);
        check_val("tmo_busy", busy_o, 0);
        check_val("tmo_req", ddr_rd_req_o, 0);
        check_val("tmo_done", done_cnt, 0);
        no_resp = 0;
        run_xfer("tmo_clear", 30'h0, 0, 0, 1'b0);

        // Abort partway through a block.
        clear_stats();
        ready_mode = 0;
        stall_en = 0;
        base_addr_i = 30'h4000;
        byte_count_i = 24'd256;
        tick(1'b1, 1'b0);
        budget = 0;
        while (got.size() < 100 && budget < 2000) begin
            tick(1'b0, 1'b0);
            budget++;
        end
        check_val("abort_reach", budget < 2000, 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check_val("abort_busy", busy_o, 0);
        check_val("abort_req", ddr_rd_req_o, 0);
        check_val("abort_rd_en", fifo_rd_en_o, 0);
        check_val("abort_tx_valid", tx_valid_o, 0);
        build_exp(30'h4000, 256);
        check_val("abort_prefix", prefix_mism(), 0);
        tick(1'b0, 1'b0);
        check_val("abort_no_done", done_cnt, 0);
        run_xfer("abort_zero", 30'h0, 0, 0, 1'b0);

        // Reset asserted mid-transfer.
        clear_stats();
        base_addr_i = 30'h8000;
        byte_count_i = 24'd600;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("mrst_busy", busy_o, 0);
        check_val("mrst_tx_valid", tx_valid_o, 0);
        check_val("mrst_rd_en", fifo_rd_en_o, 0);
        check_val("mrst_addr", ddr_address_o, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        run_xfer("post_rst", 30'($urandom), 50, 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
